// File: rtl/cond_flag_unit.sv
`default_nettype none
// ============================================================================
// Module      : cond_flag_unit
// Description : Architectural SZCV flag register for the simple CPU.
//               Applies masked flag writes from the shift/ALU units,
//               evaluates 4-bit branch condition codes against the flags the
//               register will hold after the current edge (write bypass), and
//               optionally saves/restores flags on a small LIFO for interrupt
//               entry/return.
//
//               Optional feature macro: COND_FLAG_STACK_EN
//                 defined   -> save stack, push/pop, stack_cnt, ovf, unf live
//                 undefined -> no stack; push/pop/err_clr ignored, stack_cnt,
//                              ovf and unf tied to zero
//
// Ports       : clk, rst_n              clock / async active-low reset
//               flag_we, flag_in,
//               flag_mask               masked SZCV write ([3]=S .. [0]=V)
//               cond_valid, cond        condition evaluation request
//               push, pop, err_clr      save stack control / sticky error clear
//               flags                   current SZCV register
//               take_valid, take        condition result (1-cycle latency)
//               stack_cnt               occupied stack entries
//               ovf, unf                sticky push-on-full / pop-on-empty
//
// Revision    : 1.0 - initial release
// ============================================================================
module cond_flag_unit #(
    parameter int DEPTH = 4,    // save-stack entries (2..16)
    parameter int CW    = 3     // stack count width, 2**CW > DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flag_we,
    input  logic [3:0]    flag_in,
    input  logic [3:0]    flag_mask,
    input  logic          cond_valid,
    input  logic [3:0]    cond,
    input  logic          push,
    input  logic          pop,
    input  logic          err_clr,
    output logic [3:0]    flags,
    output logic          take_valid,
    output logic          take,
    output logic [CW-1:0] stack_cnt,
    output logic          ovf,
    output logic          unf
);

    // Condition code encodings
    localparam logic [3:0] c_eq = 4'h0;
    localparam logic [3:0] c_ne = 4'h1;
    localparam logic [3:0] c_cs = 4'h2;
    localparam logic [3:0] c_cc = 4'h3;
    localparam logic [3:0] c_mi = 4'h4;
    localparam logic [3:0] c_pl = 4'h5;
    localparam logic [3:0] c_vs = 4'h6;
    localparam logic [3:0] c_vc = 4'h7;
    localparam logic [3:0] c_hi = 4'h8;
    localparam logic [3:0] c_ls = 4'h9;
    localparam logic [3:0] c_ge = 4'hA;
    localparam logic [3:0] c_lt = 4'hB;
    localparam logic [3:0] c_gt = 4'hC;
    localparam logic [3:0] c_le = 4'hD;
    localparam logic [3:0] c_al = 4'hE;

    logic [3:0] r_flags;
    logic       r_take_valid;
    logic       r_take;
    logic [3:0] w_flags_wr;     // register value after the masked write only
    logic [3:0] w_flags_nxt;    // value the register takes at this edge

    function automatic logic f_cond(input logic [3:0] code, input logic [3:0] f);
        logic s, z, c, v;
        logic r;
        s = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (code)
            c_eq:    r = z;
            c_ne:    r = ~z;
            c_cs:    r = c;
            c_cc:    r = ~c;
            c_mi:    r = s;
            c_pl:    r = ~s;
            c_vs:    r = v;
            c_vc:    r = ~v;
            c_hi:    r = c & ~z;
            c_ls:    r = ~c | z;
            c_ge:    r = ~(s ^ v);
            c_lt:    r = s ^ v;
            c_gt:    r = ~z & ~(s ^ v);
            c_le:    r = z | (s ^ v);
            c_al:    r = 1'b1;
            default: r = 1'b0;          // NV
        endcase
        return r;
    endfunction

    assign w_flags_wr = flag_we ? ((r_flags & ~flag_mask) | (flag_in & flag_mask))
                                : r_flags;

`ifdef COND_FLAG_STACK_EN
    localparam logic [CW-1:0] c_depth = CW'(DEPTH);

    logic [3:0]    r_stack [DEPTH];
    logic [CW-1:0] r_cnt;
    logic          r_ovf;
    logic          r_unf;
    logic          w_push_req;
    logic          w_pop_req;
    logic          w_full;
    logic          w_empty;
    logic          w_push_ok;
    logic          w_pop_ok;
    logic [3:0]    w_top;

    // Simultaneous push and pop cancel each other without raising an error.
    assign w_push_req = push & ~pop;
    assign w_pop_req  = pop & ~push;
    assign w_full     = (r_cnt == c_depth);
    assign w_empty    = (r_cnt == '0);
    assign w_push_ok  = w_push_req & ~w_full;
    assign w_pop_ok   = w_pop_req & ~w_empty;

    // Top-of-stack mux, written as a compare per entry so the index never
    // needs a width conversion from the count.
    always_comb begin
        w_top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_cnt == CW'(i + 1)) begin
                w_top = r_stack[i];
            end
        end
    end

    // Stack storage needs no reset: entries above the count are never read.
    // A push saves the pre-write register, not the merged value.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (w_push_ok && (r_cnt == CW'(gi))) begin
                r_stack[gi] <= r_flags;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_cnt <= r_cnt + CW'(1);
            end else if (w_pop_ok) begin
                r_cnt <= r_cnt - CW'(1);
            end
            // A new error event wins over a same-cycle clear.
            r_ovf <= (w_push_req & w_full)  | (r_ovf & ~err_clr);
            r_unf <= (w_pop_req  & w_empty) | (r_unf & ~err_clr);
        end
    end

    // A successful pop restores the saved flags and discards any write.
    assign w_flags_nxt = w_pop_ok ? w_top : w_flags_wr;
    assign stack_cnt   = r_cnt;
    assign ovf         = r_ovf;
    assign unf         = r_unf;
`else
    localparam int c_depth_unused = DEPTH;
    logic          w_stack_ctl_unused;

    assign w_stack_ctl_unused = ^{push, pop, err_clr};
    assign w_flags_nxt        = w_flags_wr;
    assign stack_cnt          = '0;
    assign ovf                = 1'b0;
    assign unf                = 1'b0;
`endif

    // Condition results use w_flags_nxt so a same-cycle write or pop is seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags      <= '0;
            r_take_valid <= 1'b0;
            r_take       <= 1'b0;
        end else begin
            r_flags      <= w_flags_nxt;
            r_take_valid <= cond_valid;
            if (cond_valid) begin
                r_take <= f_cond(cond, w_flags_nxt);
            end
        end
    end

    assign flags      = r_flags;
    assign take_valid = r_take_valid;
    assign take       = r_take;

endmodule
`default_nettype wire

// File: tb/tb_cond_flag_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_cond_flag_unit
// Description : Self-checking bench for cond_flag_unit. A behavioural model
//               (flag value, stack array, condition predicates) predicts all
//               outputs; a negedge process compares them every cycle, and
//               directed steps pin the model with hand-computed literals.
//               Follows COND_FLAG_STACK_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cond_flag_unit;

    localparam int DEPTH = 4;
    localparam int CW    = 3;
`ifdef COND_FLAG_STACK_EN
    localparam bit STACK_EN = 1'b1;
`else
    localparam bit STACK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flag_we;
    logic [3:0]    flag_in;
    logic [3:0]    flag_mask;
    logic          cond_valid;
    logic [3:0]    cond;
    logic          push;
    logic          pop;
    logic          err_clr;
    logic [3:0]    flags;
    logic          take_valid;
    logic          take;
    logic [CW-1:0] stack_cnt;
    logic          ovf;
    logic          unf;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    cond_flag_unit #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flag_we    (flag_we),
        .flag_in    (flag_in),
        .flag_mask  (flag_mask),
        .cond_valid (cond_valid),
        .cond       (cond),
        .push       (push),
        .pop        (pop),
        .err_clr    (err_clr),
        .flags      (flags),
        .take_valid (take_valid),
        .take       (take),
        .stack_cnt  (stack_cnt),
        .ovf        (ovf),
        .unf        (unf)
    );

    // ---------------- behavioural model ----------------
    logic [3:0] m_flags;
    logic       m_tv;
    logic       m_take;
    int         m_cnt;
    logic       m_ovf;
    logic       m_unf;
    logic [3:0] m_stack [16];
    logic [3:0] m_eff;
    bit         m_do_push;
    bit         m_do_pop;
    bit         m_ovf_ev;
    bit         m_unf_ev;

    // Predicates come in pairs: even code = base predicate, odd = its negation.
    function automatic bit m_cond(input logic [3:0] c, input logic [3:0] f);
        bit s, z, k, v, base;
        s = f[3]; z = f[2]; k = f[1]; v = f[0];
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = k;
            3'd2:    base = s;
            3'd3:    base = v;
            3'd4:    base = k && !z;
            3'd5:    base = (s == v);
            3'd6:    base = !z && (s == v);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    always_comb begin
        m_eff     = m_flags;
        m_do_push = STACK_EN && push && !pop && (m_cnt < DEPTH);
        m_do_pop  = STACK_EN && pop && !push && (m_cnt > 0);
        m_ovf_ev  = STACK_EN && push && !pop && (m_cnt == DEPTH);
        m_unf_ev  = STACK_EN && pop && !push && (m_cnt == 0);
        for (int i = 0; i < 4; i++) begin
            if (flag_we && flag_mask[i]) m_eff[i] = flag_in[i];
        end
        if (m_do_pop) m_eff = m_stack[m_cnt-1];
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_flags <= 4'h0;
            m_tv    <= 1'b0;
            m_take  <= 1'b0;
            m_cnt   <= 0;
            m_ovf   <= 1'b0;
            m_unf   <= 1'b0;
        end else begin
            m_flags <= m_eff;
            m_tv    <= cond_valid;
            if (cond_valid) m_take <= m_cond(cond, m_eff);
            if (m_do_push) begin
                m_stack[m_cnt] <= m_flags;
                m_cnt          <= m_cnt + 1;
            end else if (m_do_pop) begin
                m_cnt <= m_cnt - 1;
            end
            m_ovf <= m_ovf_ev ? 1'b1 : (err_clr ? 1'b0 : m_ovf);
            m_unf <= m_unf_ev ? 1'b1 : (err_clr ? 1'b0 : m_unf);
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("flags",      8'(flags),      8'(m_flags));
            chk("take_valid", 8'(take_valid), 8'(m_tv));
            chk("take",       8'(take),       8'(m_take));
            chk("stack_cnt",  8'(stack_cnt),  8'(m_cnt));
            chk("ovf",        8'(ovf),        8'(m_ovf));
            chk("unf",        8'(unf),        8'(m_unf));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic we, input logic [3:0] fi, input logic [3:0] mk,
                       input logic cv, input logic [3:0] c,
                       input logic pu, input logic po, input logic ec);
        flag_we = we; flag_in = fi; flag_mask = mk;
        cond_valid = cv; cond = c;
        push = pu; pop = po; err_clr = ec;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    logic [3:0] pats [6];

    initial begin
        pats = '{4'b0000, 4'b0100, 4'b0010, 4'b1001, 4'b0110, 4'b1111};
        rst_n = 1'b0;
        flag_we = 0; flag_in = 0; flag_mask = 0; cond_valid = 0; cond = 0;
        push = 0; pop = 0; err_clr = 0;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        chk("rst_flags", 8'(flags), 8'h0);
        chk("rst_tv",    8'(take_valid), 8'h0);
        chk("rst_cnt",   8'(stack_cnt), 8'h0);

        // Plain write, then EQ one cycle later
        cyc(1, 4'b0100, 4'b1111, 0, 4'h0, 0, 0, 0);
        chk("wr_flags", 8'(flags), 8'h4);
        cyc(0, 4'h0, 4'h0, 1, 4'h0, 0, 0, 0);
        chk("eq_tv", 8'(take_valid), 8'h1);
        chk("eq_take", 8'(take), 8'h1);
        idle();
        chk("idle_tv", 8'(take_valid), 8'h0);
        chk("hold_take", 8'(take), 8'h1);

        // Masked write with bypass: CS sees new C
        cyc(1, 4'b1010, 4'b0010, 1, 4'h2, 0, 0, 0);
        chk("mask_flags", 8'(flags), 8'h6);
        chk("byp_cs", 8'(take), 8'h1);
        // Clearing Z with EQ in the same cycle must read the new Z=0
        cyc(1, 4'b0000, 4'b0100, 1, 4'h0, 0, 0, 0);
        chk("byp_eq", 8'(take), 8'h0);
        chk("byp_flags", 8'(flags), 8'h2);

        // S=1,V=0: GE/LT/AL/NV back to back
        cyc(1, 4'b1000, 4'b1111, 0, 4'h0, 0, 0, 0);
        cyc(0, 4'h0, 4'h0, 1, 4'hA, 0, 0, 0);
        chk("ge", 8'({take_valid, take}), 8'h2);
        cyc(0, 4'h0, 4'h0, 1, 4'hB, 0, 0, 0);
        chk("lt", 8'({take_valid, take}), 8'h3);
        cyc(0, 4'h0, 4'h0, 1, 4'hE, 0, 0, 0);
        chk("al", 8'({take_valid, take}), 8'h3);
        cyc(0, 4'h0, 4'h0, 1, 4'hF, 0, 0, 0);
        chk("nv", 8'({take_valid, take}), 8'h2);

        // Sweep every condition against several flag patterns (bypassed)
        for (int p = 0; p < 6; p++) begin
            for (int c = 0; c < 16; c++) begin
                cyc(1, pats[p], 4'hF, 1, 4'(c), 0, 0, 0);
            end
        end
        idle();

`ifdef COND_FLAG_STACK_EN
        cyc(1, 4'b0001, 4'hF, 0, 4'h0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 4'(i + 2), 4'hF, 0, 4'h0, 1, 0, 0);
        end
        chk("full_cnt", 8'(stack_cnt), 8'h4);
        chk("ovf_set", 8'(ovf), 8'h1);
        chk("full_flags", 8'(flags), 8'h6);
        cyc(0, 4'h0, 4'h0, 0, 4'h0, 0, 1, 0);
        chk("pop1", 8'(flags), 8'h4);
        cyc(0, 4'h0, 4'h0, 0, 4'h0, 0, 1, 0);
        chk("pop2", 8'(flags), 8'h3);
        cyc(0, 4'h0, 4'h0, 0, 4'h0, 0, 1, 0);
        chk("pop3", 8'(flags), 8'h2);
        cyc(0, 4'h0, 4'h0, 0, 4'h0, 0, 1, 0);
        chk("pop4", 8'(flags), 8'h1);
        chk("empty_cnt", 8'(stack_cnt), 8'h0);
        cyc(0, 4'h0, 4'h0, 0, 4'h0, 0, 1, 0);
        chk("unf_set", 8'(unf), 8'h1);
        chk("unf_flags", 8'(flags), 8'h1);
        cyc(0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 1);
        chk("err_clr", 8'({ovf, unf}), 8'h0);

        // Pop discards same-cycle write; LS evaluated on the popped value
        cyc(1, 4'b0011, 4'hF, 0, 4'h0, 0, 0, 0);
        cyc(1, 4'b0000, 4'hF, 0, 4'h0, 1, 0, 0);
        cyc(1, 4'b1111, 4'hF, 1, 4'h9, 0, 1, 0);
        chk("pop_wr_flags", 8'(flags), 8'h3);
        chk("pop_ls", 8'(take), 8'h0);

        // Push+pop together: no stack change, no error, write applies
        cyc(0, 4'h0, 4'h0, 0, 4'h0, 1, 0, 0);
        cyc(1, 4'b1000, 4'b1000, 0, 4'h0, 1, 1, 0);
        chk("pp_cnt", 8'(stack_cnt), 8'h1);
        chk("pp_err", 8'({ovf, unf}), 8'h0);
        chk("pp_flags", 8'(flags), 8'hB);

        // Error set wins over same-cycle clear
        cyc(0, 4'h0, 4'h0, 0, 4'h0, 0, 1, 0);
        cyc(0, 4'h0, 4'h0, 0, 4'h0, 0, 1, 1);
        chk("unf_wins", 8'(unf), 8'h1);
        cyc(0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 1);

        cyc(0, 4'h0, 4'h0, 0, 4'h0, 1, 0, 0);
        cyc(0, 4'h0, 4'h0, 0, 4'h0, 1, 0, 0);
        chk("two_cnt", 8'(stack_cnt), 8'h2);
`else
        for (int i = 0; i < 6; i++) begin
            cyc(0, 4'h0, 4'h0, 0, 4'h0, 1, 0, 0);
        end
        chk("nostk_cnt", 8'(stack_cnt), 8'h0);
        chk("nostk_ovf", 8'(ovf), 8'h0);
        cyc(1, 4'b0101, 4'hF, 0, 4'h0, 0, 1, 0);
        chk("nostk_pop_wr", 8'(flags), 8'h5);
        chk("nostk_unf", 8'(unf), 8'h0);
`endif

        // Reset in the middle of a condition burst
        cyc(1, 4'b1111, 4'hF, 1, 4'hE, 0, 0, 0);
        cyc(0, 4'h0, 4'h0, 1, 4'hE, 0, 0, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_flags", 8'(flags), 8'h0);
        chk("arst_tv",    8'(take_valid), 8'h0);
        chk("arst_take",  8'(take), 8'h0);
        chk("arst_cnt",   8'(stack_cnt), 8'h0);
        chk("arst_err",   8'({ovf, unf}), 8'h0);
        flag_we = 0; cond_valid = 0; push = 0; pop = 0; err_clr = 0;
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        cyc(1, 4'b0100, 4'b0100, 1, 4'h0, 0, 0, 0);
        chk("post_rst_eq", 8'(take), 8'h1);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
